cpu7_exu_hzdctl: RTL and testbench

Pipeline hazard controller for the EXU's E/M/W bypass network. It keeps a shadow copy of destination-register state for the E, M and W stages and produces the rd/wen tags consumed by the per-operand bypass selectors. It detects load-use hazards, sequences the multi-cycle divider in E, and honours LSU back-pressure and flushes. It stalls decode and injects bubbles into E as required.

---
 rtl/cpu7_exu_hzdctl.sv | 135 +++++++++++++
 tb/tb_cpu7_exu_hzdctl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu7_exu_hzdctl.sv
// EXU hazard controller: shadows E/M/W destination state, drives bypass tags,
// detects load-use hazards, sequences the multi-cycle divider and handles stalls/flushes.
module cpu7_exu_hzdctl #(
    parameter int unsigned DIV_LAT = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       valid_d,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic       rs1_en_d,
    input  logic       rs2_en_d,
    input  logic [4:0] rd_d,
    input  logic       wen_d,
    input  logic       ld_d,
    input  logic       div_d,
    input  logic       lsu_stall,
    input  logic       flush,
    output logic       stall_d,
    output logic       div_busy,
    output logic [4:0] byp_rd_m,
    output logic [4:0] byp_rd_w,
    output logic       byp_wen_m,
    output logic       byp_wen_w
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_e;

    div_state_e state, state_nxt;
    logic [4:0] cnt_e, cnt_nxt;

    logic       valid_e, wen_e, ld_e, div_e;
    logic [4:0] rd_e;
    logic       valid_m, wen_m, ld_m;
    logic [4:0] rd_m;
    logic       valid_w, wen_w;
    logic [4:0] rd_w;

    logic load_use, div_hold, advance, take_d;

    always_comb begin
        load_use = valid_d & valid_e & ld_e & wen_e & (rd_e != 5'd0) &
                   ((rs1_en_d & (rs1_d == rd_e)) | (rs2_en_d & (rs2_d == rd_e)));
        div_hold = valid_e & div_e & (cnt_e != 5'd0);
        advance  = ~lsu_stall & ~div_hold;
        take_d   = valid_d & ~flush & ~load_use;
    end

    // Divider sequencer; cnt only moves while the LSU is not freezing the pipe.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_e;
        unique case (state)
            IDLE: begin
                if (advance && take_d && div_d) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 5'(DIV_LAT - 1);
                end
            end
            BUSY: begin
                if (!lsu_stall) begin
                    cnt_nxt = cnt_e - 5'd1;
                    if (cnt_e == 5'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt_e <= '0;
        end else begin
            state <= state_nxt;
            cnt_e <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_e <= 1'b0;
            rd_e    <= '0;
            wen_e   <= 1'b0;
            ld_e    <= 1'b0;
            div_e   <= 1'b0;
            valid_m <= 1'b0;
            rd_m    <= '0;
            wen_m   <= 1'b0;
            ld_m    <= 1'b0;
            valid_w <= 1'b0;
            rd_w    <= '0;
            wen_w   <= 1'b0;
        end else if (advance) begin
            valid_w <= valid_m;
            rd_w    <= rd_m;
            wen_w   <= wen_m;
            valid_m <= valid_e;
            rd_m    <= rd_e;
            wen_m   <= wen_e;
            ld_m    <= ld_e;
            valid_e <= take_d;
            rd_e    <= rd_d;
            wen_e   <= wen_d;
            ld_e    <= ld_d;
            div_e   <= div_d;
        end else begin
            // While the divider holds E, older instructions keep retiring out of M/W.
            if (div_hold && !lsu_stall) begin
                valid_w <= valid_m;
                rd_w    <= rd_m;
                wen_w   <= wen_m;
                valid_m <= 1'b0;
            end
            if (flush) valid_e <= 1'b0;
        end
    end

    always_comb begin
        stall_d   = resetn & ~flush & (lsu_stall | div_hold | load_use);
        div_busy  = div_hold;
        byp_rd_m  = rd_m;
        byp_rd_w  = rd_w;
        byp_wen_m = valid_m & wen_m & ~ld_m;
        byp_wen_w = valid_w & wen_w;
    end

endmodule

// File: tb/tb_cpu7_exu_hzdctl.sv
// Directed bench for cpu7_exu_hzdctl: per-cycle expected outputs are queued by the
// stimulus and compared by an independent negedge monitor.
module tb_cpu7_exu_hzdctl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       valid_d;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       rs1_en_d, rs2_en_d, wen_d, ld_d, div_d;
    logic       lsu_stall, flush;
    logic       stall_d, div_busy, byp_wen_m, byp_wen_w;
    logic [4:0] byp_rd_m, byp_rd_w;

    cpu7_exu_hzdctl #(.DIV_LAT(16)) dut (
        .clk(clk), .resetn(resetn), .valid_d(valid_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_en_d(rs1_en_d), .rs2_en_d(rs2_en_d),
        .rd_d(rd_d), .wen_d(wen_d), .ld_d(ld_d), .div_d(div_d),
        .lsu_stall(lsu_stall), .flush(flush),
        .stall_d(stall_d), .div_busy(div_busy),
        .byp_rd_m(byp_rd_m), .byp_rd_w(byp_rd_w),
        .byp_wen_m(byp_wen_m), .byp_wen_w(byp_wen_w)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       stall;
        logic       busy;
        logic [4:0] rdm;
        logic       wm;
        logic [4:0] rdw;
        logic       ww;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad   = 0;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = sb_q.pop_front();
            nm = nm_q.pop_front();
            a  = '{stall_d, div_busy, byp_rd_m, byp_wen_m, byp_rd_w, byp_wen_w};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s @%0t: got stall=%0b busy=%0b rdm=%0d wm=%0b rdw=%0d ww=%0b, want stall=%0b busy=%0b rdm=%0d wm=%0b rdw=%0d ww=%0b",
                         nm, $time, a.stall, a.busy, a.rdm, a.wm, a.rdw, a.ww,
                         e.stall, e.busy, e.rdm, e.wm, e.rdw, e.ww);
            end
        end
    end

    task automatic set_d(input logic v, input logic [4:0] rd, input logic w, input logic l,
                         input logic dv, input logic [4:0] r1, input logic e1,
                         input logic [4:0] r2, input logic e2);
        valid_d = v; rd_d = rd; wen_d = w; ld_d = l; div_d = dv;
        rs1_d = r1; rs1_en_d = e1; rs2_d = r2; rs2_en_d = e2;
    endtask

    task automatic nop();
        set_d(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // Queue the expected outputs for the current cycle, then move to the next cycle.
    task automatic cyc(input string nm, input logic st, input logic bs, input logic [4:0] rm,
                       input logic wm, input logic [4:0] rw, input logic ww);
        exp_t e;
        e = '{st, bs, rm, wm, rw, ww};
        sb_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; lsu_stall = 1'b0; flush = 1'b0;
        nop();
        @(posedge clk); #1;
        cyc("reset", 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;

        // load-use: ld r5 ; add r6,r5,r1
        set_d(1, 5'd5, 1, 1, 0, 5'd0, 0, 5'd0, 0);  cyc("lu_c0", 0, 0, 0, 0, 0, 0);
        set_d(1, 5'd6, 1, 0, 0, 5'd5, 1, 5'd1, 1);  cyc("lu_stall", 1, 0, 0, 0, 0, 0);
        cyc("lu_m_noload_byp", 0, 0, 5, 0, 0, 0);
        nop();                                       cyc("lu_w_byp", 0, 0, 6, 0, 5, 1);
        cyc("lu_c4", 0, 0, 6, 1, 6, 0);
        cyc("lu_c5", 0, 0, 0, 0, 6, 1);
        cyc("lu_c6", 0, 0, 0, 0, 0, 0);

        // ld r0 + reader of r0, ld r5 + disabled rs1 = 5
        set_d(1, 5'd0, 1, 1, 0, 5'd0, 0, 5'd0, 0);  cyc("r0_c0", 0, 0, 0, 0, 0, 0);
        set_d(1, 5'd1, 1, 0, 0, 5'd0, 1, 5'd0, 1);  cyc("r0_nostall", 0, 0, 0, 0, 0, 0);
        set_d(1, 5'd5, 1, 1, 0, 5'd0, 0, 5'd0, 0);  cyc("r0_c2", 0, 0, 0, 0, 0, 0);
        set_d(1, 5'd3, 1, 0, 0, 5'd5, 0, 5'd2, 1);  cyc("rsen_nostall", 0, 0, 1, 1, 0, 1);
        nop();                                       cyc("r0_c4", 0, 0, 5, 0, 1, 1);
        cyc("r0_c5", 0, 0, 3, 1, 5, 1);
        cyc("r0_c6", 0, 0, 0, 0, 3, 1);
        cyc("r0_c7", 0, 0, 0, 0, 0, 0);

        // div r7, then add r8 waiting in D
        set_d(1, 5'd7, 1, 0, 1, 5'd0, 0, 5'd0, 0);  cyc("div_enter", 0, 0, 0, 0, 0, 0);
        set_d(1, 5'd8, 1, 0, 0, 5'd0, 0, 5'd0, 0);
        for (int i = 0; i < 15; i++) cyc("div_busy", 1, 1, 0, 0, 0, 0);
        cyc("div_done", 0, 0, 0, 0, 0, 0);
        nop();                                       cyc("div_in_m", 0, 0, 7, 1, 0, 0);
        cyc("div_in_w", 0, 0, 8, 1, 7, 1);
        cyc("div_c18", 0, 0, 0, 0, 8, 1);
        cyc("div_c19", 0, 0, 0, 0, 0, 0);

        // LSU freeze for 3 cycles with ALU ops in E/M/W
        set_d(1, 5'd1, 1, 0, 0, 5'd0, 0, 5'd0, 0);  cyc("lsu_c0", 0, 0, 0, 0, 0, 0);
        set_d(1, 5'd2, 1, 0, 0, 5'd0, 0, 5'd0, 0);  cyc("lsu_c1", 0, 0, 0, 0, 0, 0);
        set_d(1, 5'd3, 1, 0, 0, 5'd0, 0, 5'd0, 0);  cyc("lsu_c2", 0, 0, 1, 1, 0, 0);
        set_d(1, 5'd4, 1, 0, 0, 5'd0, 0, 5'd0, 0);
        lsu_stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc("lsu_freeze", 1, 0, 2, 1, 1, 1);
        lsu_stall = 1'b0;                            cyc("lsu_resume", 0, 0, 2, 1, 1, 1);
        nop();                                       cyc("lsu_c7", 0, 0, 3, 1, 2, 1);
        cyc("lsu_c8", 0, 0, 4, 1, 3, 1);
        cyc("lsu_c9", 0, 0, 0, 0, 4, 1);
        cyc("lsu_c10", 0, 0, 0, 0, 0, 0);

        // flush at cnt = 9 during div r9
        set_d(1, 5'd9, 1, 0, 1, 5'd0, 0, 5'd0, 0);  cyc("fl_enter", 0, 0, 0, 0, 0, 0);
        nop();
        for (int i = 0; i < 6; i++) cyc("fl_busy", 1, 1, 0, 0, 0, 0);
        flush = 1'b1;                                cyc("fl_cycle", 0, 1, 0, 0, 0, 0);
        flush = 1'b0;                                cyc("fl_idle", 0, 0, 0, 0, 0, 0);
        cyc("fl_e_killed", 0, 0, 9, 0, 0, 0);
        cyc("fl_c10", 0, 0, 0, 0, 9, 0);
        cyc("fl_c11", 0, 0, 0, 0, 0, 0);

        // lsu_stall freezes the divide counter
        set_d(1, 5'd10, 1, 0, 1, 5'd0, 0, 5'd0, 0); cyc("frz_enter", 0, 0, 0, 0, 0, 0);
        nop();
        lsu_stall = 1'b1;
        for (int i = 0; i < 2; i++) cyc("frz_lsu", 1, 1, 0, 0, 0, 0);
        lsu_stall = 1'b0;
        for (int i = 0; i < 15; i++) cyc("frz_busy", 1, 1, 0, 0, 0, 0);
        cyc("frz_done", 0, 0, 0, 0, 0, 0);
        cyc("frz_in_m", 0, 0, 10, 1, 0, 0);
        cyc("frz_in_w", 0, 0, 0, 0, 10, 1);
        cyc("frz_c21", 0, 0, 0, 0, 0, 0);

        // async reset during a divide and an lsu_stall
        set_d(1, 5'd11, 1, 0, 1, 5'd0, 0, 5'd0, 0); cyc("rst_div", 0, 0, 0, 0, 0, 0);
        nop();
        cyc("rst_busy", 1, 1, 0, 0, 0, 0);
        cyc("rst_busy", 1, 1, 0, 0, 0, 0);
        lsu_stall = 1'b1;
        resetn = 1'b0;                               cyc("rst_async", 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        lsu_stall = 1'b0;
        set_d(1, 5'd12, 1, 0, 0, 5'd0, 0, 5'd0, 0); cyc("rst_rel", 0, 0, 0, 0, 0, 0);
        nop();                                       cyc("rst_e", 0, 0, 0, 0, 0, 0);
        cyc("rst_m", 0, 0, 12, 1, 0, 0);
        cyc("rst_w", 0, 0, 0, 0, 12, 1);
        cyc("rst_end", 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
